// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package adder_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // word_sel works on fixed-size containers: operands up to VEC_MAX bits,
  // words up to WORD_MAX bits. Callers cast in and out of these sizes.
  localparam int unsigned VEC_MAX  = 1024;
  localparam int unsigned WORD_MAX = 128;

  // Extract word number idx (each width bits wide) from vec, LSW = word 0.
  function automatic logic [WORD_MAX-1:0] word_sel(input logic [VEC_MAX-1:0] vec,
                                                   input int unsigned       idx,
                                                   input int unsigned       width);
    logic [VEC_MAX-1:0] shifted;
    shifted = vec >> (idx * width);
    return shifted[WORD_MAX-1:0];
  endfunction

endpackage

// File: rtl/multiword_add_seq_rca.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module RippleCarryAdder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit adder, one word per
// cycle, least-significant word first, carry fed back between words.
//
// Handshake: start is sampled only in IDLE; a high start there accepts the
// operands. busy is high from the cycle after accept through the DONE cycle.
// done is a one-cycle pulse during which s/cout/ovf are valid; they then hold
// until the next accept, which clears s and leaves cout/ovf stale until the
// following done. start while busy is dropped, never queued.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout,
  output logic                   ovf,
  output seq_state_t             state_dbg
);

  localparam int unsigned VW    = WIDTH * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_t       state_q;
  logic [VW-1:0]    a_q;
  logic [VW-1:0]    b_q;
  logic             sub_q;
  logic [VW-1:0]    s_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_w;
  logic             add_cout;
  logic             ovf_d;

  // Operand muxing for the current word; b is inverted for subtraction and
  // the +1 comes from the carry register being preset to sub on accept.
  always_comb begin
    a_word = WIDTH'(word_sel(VEC_MAX'(a_q), 32'(idx_q), WIDTH));
    b_eff  = WIDTH'(word_sel(VEC_MAX'(b_q), 32'(idx_q), WIDTH)) ^ {WIDTH{sub_q}};
    // Only meaningful on the top word: same-sign inputs giving a sum of the
    // other sign.
    ovf_d  = (a_word[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_word[WIDTH-1]);
  end

  RippleCarryAdder #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a_i   (a_word),
    .b_i   (b_eff),
    .cin_i (c_q),
    .sum_o (sum_w),
    .cout_o(add_cout)
  );

  // Sequencer FSM with registered outputs; reset wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            s_q     <= '0;
            idx_q   <= '0;
            c_q     <= sub;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q[32'(idx_q) * WIDTH +: WIDTH] <= sum_w;
          c_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= add_cout;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: a 4x8-bit instance for the main
// scenarios and a 1x8-bit instance for the single-word configuration.
module tb_multiword_add_seq;
  import adder_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WIDTH * WORDS;
  localparam int unsigned W1    = WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-word instance
  logic         start, sub;
  logic [W-1:0] a, b, s;
  logic         busy, done, cout, ovf;
  seq_state_t   state_dbg;

  // 1-word instance
  logic          start1, sub1;
  logic [W1-1:0] a1, b1, s1;
  logic          busy1, done1, cout1, ovf1;
  seq_state_t    state_dbg1;

  int checks = 0;
  int errors = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .state_dbg(state_dbg)
  );

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1), .state_dbg(state_dbg1)
  );

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned result/carry and signed range check.
  function automatic void ref_model(input int w, input longint unsigned av, input longint unsigned bv,
                                    input bit sv, output longint unsigned sr, output bit cr,
                                    output bit orr);
    longint unsigned mask, full;
    longint lim, sa, sb, sres;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = (((av >> (w - 1)) & 64'd1) != 0) ? longint'(av) - 2 * lim : longint'(av);
    sb   = (((bv >> (w - 1)) & 64'd1) != 0) ? longint'(bv) - 2 * lim : longint'(bv);
    if (sv) begin
      sr   = (av - bv) & mask;
      cr   = (av >= bv);
      sres = sa - sb;
    end else begin
      full = av + bv;
      sr   = full & mask;
      cr   = ((full >> w) != 0);
      sres = sa + sb;
    end
    orr = (sres >= lim) || (sres < -lim);
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge with the DUT idle. lat is the
  // number of edges after the accept edge at which done is first seen.
  task automatic drive_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v,
                          output int lat, output int pulses, output bit busy_run_ok,
                          output bit busy_end_ok);
    a = a_v; b = b_v; sub = sub_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble operands after accept
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    lat = 0; pulses = 0; busy_run_ok = 1'b1; busy_end_ok = 1'b1;
    for (int i = 1; i <= int'(WORDS) + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (i <= int'(WORDS) && busy !== 1'b1) busy_run_ok = 1'b0;
      if (i > int'(WORDS) && busy !== 1'b0) busy_end_ok = 1'b0;
    end
  endtask

  task automatic drive_op1(input logic [W1-1:0] a_v, input logic [W1-1:0] b_v, input logic sub_v,
                           output int lat, output int pulses);
    a1 = a_v; b1 = b_v; sub1 = sub_v; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom);
    lat = 0; pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s !== '0)     begin errors++; $display("FAIL reset_s got %h want 0", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (s1 !== '0 || done1 !== 1'b0 || busy1 !== 1'b0)
      begin errors++; $display("FAIL reset_w1 got s=%h done=%b busy=%b want 0", s1, done1, busy1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed cases with hand-computed expectations.
  task automatic test_directed();
    logic [W-1:0] ta [6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0005,
                             32'h0000_0007, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                             32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
    logic         tsub[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] es [6] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFE,
                             32'h0000_0002, 32'h8000_0000, 32'h7FFF_FFFF};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, pulses;
    bit brun, bend;
    for (int k = 0; k < 6; k++) begin
      drive_op(ta[k], tb[k], tsub[k], lat, pulses, brun, bend);
      checks++; if (s !== es[k])    begin errors++; $display("FAIL dir%0d_s got %h want %h", k, s, es[k]); end
      checks++; if (cout !== ec[k]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", k, cout, ec[k]); end
      checks++; if (ovf !== eo[k])  begin errors++; $display("FAIL dir%0d_ovf got %b want %b", k, ovf, eo[k]); end
      checks++; if (lat != int'(WORDS)) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, WORDS); end
      checks++; if (pulses != 1)    begin errors++; $display("FAIL dir%0d_done_pulses got %0d want 1", k, pulses); end
      checks++; if (!brun || !bend) begin errors++; $display("FAIL dir%0d_busy got run=%b end=%b want 1 1", k, brun, bend); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, exp_s;
    logic rs;
    longint unsigned sr;
    bit cr, orr;
    int lat, pulses;
    bit brun, bend;
    for (int k = 0; k < 30; k++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (k % 5 == 1) rb = ra;
      if (k % 7 == 2) ra = 32'h8000_0000 | 32'($urandom_range(0, 3));
      ref_model(W, 64'(ra), 64'(rb), rs, sr, cr, orr);
      exp_s = W'(sr);
      drive_op(ra, rb, rs, lat, pulses, brun, bend);
      checks++;
      if (s !== exp_s || cout !== cr || ovf !== orr || lat != int'(WORDS) || pulses != 1) begin
        errors++;
        $display("FAIL rand%0d got s=%h c=%b o=%b lat=%0d n=%0d want s=%h c=%b o=%b lat=%0d n=1 (a=%h b=%h sub=%b)",
                 k, s, cout, ovf, lat, pulses, exp_s, cr, orr, WORDS, ra, rb, rs);
      end
    end
  endtask

  // start pulses during RUN and during DONE must be dropped.
  task automatic test_back_to_back();
    int pulses = 0;
    a = 32'h1234_5678; b = 32'h0101_0101; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= int'(WORDS) + 4; i++) begin
      if (i == 2 || i == int'(WORDS) + 1) begin
        a = $urandom; b = $urandom; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    checks++; if (s !== 32'h1335_5779) begin errors++; $display("FAIL ignore_s got %h want 13355779", s); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_done_pulses got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after got %b want 0", busy); end
  endtask

  // Results hold while idle; a new accept clears s and leaves cout/ovf stale.
  task automatic test_hold_and_clear();
    int lat, pulses;
    bit brun, bend;
    drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, pulses, brun, bend);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0)
      begin errors++; $display("FAIL hold got s=%h c=%b o=%b want 0 1 0", s, cout, ovf); end
    drive_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, pulses, brun, bend);
    checks++; if (cout !== 1'b1 || ovf !== 1'b1)
      begin errors++; $display("FAIL hold_prep got c=%b o=%b want 1 1", cout, ovf); end
    a = 32'h0000_0001; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (s !== 32'h0 || cout !== 1'b1 || ovf !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL clear_on_accept got s=%h c=%b o=%b busy=%b want 0 1 1 1", s, cout, ovf, busy); end
    pulses = 0;
    for (int i = 1; i <= int'(WORDS) + 2; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (s !== 32'h2 || cout !== 1'b0 || ovf !== 1'b0 || pulses != 1)
      begin errors++; $display("FAIL after_clear got s=%h c=%b o=%b n=%0d want 2 0 0 1", s, cout, ovf, pulses); end
  endtask

  // Reset sampled at the edge ending RUN cycle 2 aborts the operation.
  task automatic test_reset_midrun();
    int lat, pulses;
    bit brun, bend;
    drive_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, pulses, brun, bend);
    a = 32'h0102_0304; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (s !== '0 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrun_reset got s=%h c=%b o=%b busy=%b done=%b want all 0", s, cout, ovf, busy, done); end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrun_no_done got %0d want 0", pulses); end
    drive_op(32'h0102_0304, 32'h1111_1111, 1'b0, lat, pulses, brun, bend);
    checks++; if (s !== 32'h1213_1415 || lat != int'(WORDS) || pulses != 1)
      begin errors++; $display("FAIL midrun_fresh got s=%h lat=%0d n=%0d want 12131415 %0d 1", s, lat, pulses, WORDS); end
  endtask

  task automatic test_words1();
    int lat, pulses;
    logic [W1-1:0] ra, rb;
    logic rs;
    longint unsigned sr;
    bit cr, orr;
    drive_op1(8'hF0, 8'h20, 1'b0, lat, pulses);
    checks++; if (s1 !== 8'h10 || cout1 !== 1'b1 || ovf1 !== 1'b0)
      begin errors++; $display("FAIL w1_dir got s=%h c=%b o=%b want 10 1 0", s1, cout1, ovf1); end
    checks++; if (lat != 1 || pulses != 1)
      begin errors++; $display("FAIL w1_latency got lat=%0d n=%0d want 1 1", lat, pulses); end
    for (int k = 0; k < 10; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      ref_model(W1, 64'(ra), 64'(rb), rs, sr, cr, orr);
      drive_op1(ra, rb, rs, lat, pulses);
      checks++;
      if (s1 !== W1'(sr) || cout1 !== cr || ovf1 !== orr || lat != 1 || pulses != 1) begin
        errors++;
        $display("FAIL w1_rand%0d got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=1 (a=%h b=%h sub=%b)",
                 k, s1, cout1, ovf1, lat, W1'(sr), cr, orr, ra, rb, rs);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold_and_clear();
    test_reset_midrun();
    test_words1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
